// File: rtl/sub2_stage_recover_pkg.sv
// rtl/sub2_stage_recover_pkg.sv - defaults, half-width helper and stage-1 record for sub2_stage_recover
package sub2_pkg;

  localparam int WIDTH_DEF = 32;

  function automatic int half_of(input int width);
    return width / 2;
  endfunction

  localparam int HALF_DEF = WIDTH_DEF / 2;

  typedef struct packed {
    logic                valid;
    logic [HALF_DEF-1:0] d_lo;
    logic                b0;
    logic [HALF_DEF:0]   sum_hi;
    logic [HALF_DEF-1:0] a_hi;
  } s1_rec_t;

endpackage

// File: rtl/sub2_stage_recover_slice.sv
// rtl/sub2_stage_recover_slice.sv - combinational borrow-chained slice: {bout, d} = x - y - bin
module sub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_bin,
  output logic [W-1:0] o_d,
  output logic         o_bout
);

  assign {o_bout, o_d} = {1'b0, i_x} - {1'b0, i_y} - {{W{1'b0}}, i_bin};

endmodule

// File: rtl/sub2_stage_recover.sv
// rtl/sub2_stage_recover.sv - two-stage pipelined sum - a recovery with global stall
// Optional range-error flag enabled by SUB2_RANGE_CHECK_EN.
module sub2_stage_recover
  import sub2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_err
);

  localparam int HALF = half_of(WIDTH);

  typedef struct packed {
    logic            valid;
    logic [HALF-1:0] d_lo;
    logic            b0;
    logic [HALF:0]   sum_hi;
    logic [HALF-1:0] a_hi;
  } s1_t;

  s1_t             r_s1;
  logic            r_out_valid;
  logic [WIDTH-1:0] r_out_diff;

  logic            w_adv;
  logic [HALF-1:0] w_d_lo;
  logic            w_b0;
  logic [HALF:0]   w_d_hi;
  logic            w_bh;

  // One stall signal freezes both stages so nothing in flight can be overwritten.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  sub_slice #(.W(HALF)) u_lo (
    .i_x    (in_sum[HALF-1:0]),
    .i_y    (in_a[HALF-1:0]),
    .i_bin  (1'b0),
    .o_d    (w_d_lo),
    .o_bout (w_b0)
  );

  sub_slice #(.W(HALF+1)) u_hi (
    .i_x    (r_s1.sum_hi),
    .i_y    ({1'b0, r_s1.a_hi}),
    .i_bin  (r_s1.b0),
    .o_d    (w_d_hi),
    .o_bout (w_bh)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1        <= '0;
      r_out_valid <= 1'b0;
      r_out_diff  <= '0;
    end else if (w_adv) begin
      r_s1.valid  <= in_valid;
      r_s1.d_lo   <= w_d_lo;
      r_s1.b0     <= w_b0;
      r_s1.sum_hi <= in_sum[WIDTH:HALF];
      r_s1.a_hi   <= in_a[WIDTH-1:HALF];
      r_out_valid <= r_s1.valid;
      r_out_diff  <= {w_d_hi[HALF-1:0], r_s1.d_lo};
    end
  end

  assign out_valid = r_out_valid;
  assign out_diff  = r_out_diff;

`ifdef SUB2_RANGE_CHECK_EN
  logic r_out_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_err <= 1'b0;
    end else if (w_adv) begin
      r_out_err <= r_s1.valid & (w_bh | w_d_hi[HALF]);
    end
  end

  assign out_err = r_out_err;
`else
  logic w_unused_range;

  assign w_unused_range = w_bh ^ w_d_hi[HALF];
  assign out_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sub2_stage_recover.sv
// tb/tb_sub2_stage_recover.sv - self-checking bench for sub2_stage_recover
module tb_sub2_stage_recover;

  localparam int W = 32;

`ifdef SUB2_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   in_sum;
  logic [W-1:0] in_a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sub2_stage_recover #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_err   (out_err)
  );

  typedef struct {
    logic [W-1:0] diff;
    logic         err;
  } exp_t;

  typedef struct {
    logic [W:0]   sum;
    logic [W-1:0] a;
    logic [W-1:0] diff;
    logic         err_rc;
  } vec_t;

  exp_t sb[$];
  logic accepted;
  int   pops = 0;

  function automatic exp_t model(input logic [W:0] s, input logic [W-1:0] a);
    exp_t   e;
    longint d;
    d      = longint'(s) - longint'(a);
    e.diff = d[W-1:0];
    e.err  = RANGE_EN && ((d < 0) || (d >= (longint'(1) << W)));
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: sample handshakes at negedge, run the scoreboard, return 1 after posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
    accepted = in_valid && in_ready && !reset;
    if (accepted) sb.push_back(model(in_sum, in_a));
    if (out_valid && out_ready && !reset) begin
      pops++;
      if (sb.size() == 0) begin
        check("spurious_output", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("sb_diff", 64'(out_diff), 64'(e.diff));
        check("sb_err", 64'(out_err), 64'(e.err));
      end
    end
    @(posedge clock);
    #1;
  endtask

  vec_t         vecs[8];
  logic [W:0]   bp_sum[8];
  logic [W-1:0] bp_a[8];
  int           idx;
  int           pops_start;

  initial begin
    vecs[0] = '{33'h0_0001_0000, 32'h0000_FFFF, 32'h0000_0001, 1'b0};
    vecs[1] = '{33'h1_0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[2] = '{33'h0_0000_0005, 32'h0000_0006, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{33'h1_0000_0005, 32'h0000_0001, 32'h0000_0004, 1'b1};
    vecs[4] = '{33'h0_0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5] = '{33'h1_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[6] = '{33'h0_FFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{33'h0_1234_5678, 32'h0000_5679, 32'h1233_FFFF, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_a      = '0;
    out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_diff", 64'(out_diff), 64'(0));
    check("reset_out_err", 64'(out_err), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors, one at a time, checking latency.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sum   = vecs[i].sum;
      in_a     = vecs[i].a;
      cycle();
      check($sformatf("vec%0d_not_early", i), 64'(out_valid), 64'(0));
      in_valid = 1'b0;
      cycle();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("vec%0d_diff", i), 64'(out_diff), 64'(vecs[i].diff));
      check($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].err_rc & RANGE_EN));
      cycle();
      check($sformatf("vec%0d_one_shot", i), 64'(out_valid), 64'(0));
    end

    // Backpressure: 8 back-to-back items, 3-cycle output stall mid-stream.
    for (int i = 0; i < 8; i++) begin
      bp_sum[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      bp_a[i]   = 32'($urandom);
    end
    idx        = 0;
    pops_start = pops;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (idx < 8);
      in_sum    = bp_sum[idx % 8];
      in_a      = bp_a[idx % 8];
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) check($sformatf("stall_in_ready_c%0d", c), 64'(in_ready), 64'(0));
      cycle();
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(idx), 64'(8));
    check("bp_emitted", 64'(pops - pops_start), 64'(8));
    check("bp_sb_empty", 64'(sb.size()), 64'(0));

    // Reset with two items in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 33'h0_0000_0100;
    in_a      = 32'h0000_0001;
    cycle();
    in_sum    = 33'h0_0000_0200;
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    cycle();
    reset = 1'b0;
    sb.delete();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_diff", 64'(out_diff), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    out_ready  = 1'b1;
    pops_start = pops;
    for (int c = 0; c < 5; c++) cycle();
    check("midrst_no_emit", 64'(pops - pops_start), 64'(0));

    // Random traffic against the arithmetic reference model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_sum    = {1'($urandom_range(0, 1)), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) in_a = in_sum[W-1:0] + 32'($urandom_range(0, 3)) - 32'd1;
      else                           in_a = 32'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    check("rand_sb_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
